// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and golden tables
// for the gate networks it is used to check.
package tts_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  // Z = A.B + B.C with VEC = {A,B,C}; bit i is Z for VEC == i
  localparam logic [7:0] EXP_C3_1 = 8'b1100_1000;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/observe bundle between a sweep controller (master) and the sweeper (slave).
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic                   abort;
  logic                   z_in;
  logic [N_IN-1:0]        vec;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   tbl;
  logic                   pass;

  modport master (output start, abort, z_in, input  vec, busy, done, tbl, pass);
  modport slave  (input  start, abort, z_in, output vec, busy, done, tbl, pass);
endinterface

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Counts clocks a vector has been held; last flags the sampling cycle.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = $clog2(DWELL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // clr is raised on the last cycle, so cnt never exceeds DWELL-1
  assign last = (cnt == CW'(DWELL - 1));
endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a combinational network, captures its output
// into a truth table and flags whether it matches the golden table.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int                   N_IN     = 3,
  parameter int                   DWELL    = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = EXP_C3_1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  sw
);
  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx;
  logic [NV-1:0]   tbl_q;
  logic            valid;
  logic            last, clr, en, start_acc, sample, abort_acc;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sw.busy   = 1'b0;
    sw.done   = 1'b0;
    sw.vec    = '0;
    en        = 1'b0;
    clr       = 1'b0;
    start_acc = 1'b0;
    sample    = 1'b0;
    abort_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sw.start) begin
          start_acc = 1'b1;
          clr       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        sw.busy = 1'b1;
        sw.vec  = idx;
        en      = 1'b1;
        // abort wins over a sample falling on the same edge
        if (sw.abort) begin
          abort_acc = 1'b1;
          clr       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (last) begin
          sample = 1'b1;
          clr    = 1'b1;
          if (idx == IDX_LAST) state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        sw.done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      tbl_q <= '0;
      valid <= 1'b0;
    end else begin
      if (start_acc) begin
        idx   <= '0;
        tbl_q <= '0;
        valid <= 1'b0;
      end
      if (abort_acc) idx <= '0;
      if (sample) begin
        tbl_q[idx] <= sw.z_in;
        // valid rises entering FIN so pass is visible alongside done
        if (idx == IDX_LAST) valid <= 1'b1;
        else                 idx   <= idx + 1'b1;
      end
    end
  end

  assign sw.tbl  = tbl_q;
  assign sw.pass = valid && (tbl_q == EXPECTED);
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Runs a DWELL=4 and a DWELL=1 sweeper side by side against a sweep-progress
// model, with directed scenarios followed by random start/abort/reset traffic.
module tb_truth_table_sweeper;
  import tts_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] func = 8'hC8;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) if4 ();
  truth_table_sweeper_if #(.N_IN(3)) if1 ();

  assign if4.start = start;
  assign if4.abort = abort;
  assign if4.z_in  = func[if4.vec];
  assign if1.start = start;
  assign if1.abort = abort;
  assign if1.z_in  = func[if1.vec];

  truth_table_sweeper #(.N_IN(3), .DWELL(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .sw(if4.slave));
  truth_table_sweeper #(.N_IN(3), .DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .sw(if1.slave));

  // p = number of drive edges completed in the current sweep
  typedef struct {
    bit       act;
    bit       fin;
    bit       valid;
    int       p;
    bit [7:0] tbl;
  } mdl_t;

  mdl_t m [2];
  int   dw [2] = '{4, 1};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].act = 0; m[k].fin = 0; m[k].valid = 0; m[k].p = 0; m[k].tbl = '0;
    end
  endtask

  task automatic m_edge(int k);
    int d;
    d = dw[k];
    if (!rst_n) begin
      m[k].act = 0; m[k].fin = 0; m[k].valid = 0; m[k].p = 0; m[k].tbl = '0;
    end else if (m[k].fin) begin
      m[k].fin = 0;
    end else if (!m[k].act) begin
      if (start) begin
        m[k].act = 1; m[k].p = 0; m[k].tbl = '0; m[k].valid = 0;
      end
    end else if (abort) begin
      m[k].act = 0;
    end else begin
      m[k].p++;
      if (m[k].p % d == 0) m[k].tbl[m[k].p/d - 1] = func[m[k].p/d - 1];
      if (m[k].p == 8*d) begin
        m[k].act = 0; m[k].fin = 1; m[k].valid = 1;
      end
    end
  endtask

  task automatic chk_inst(int k, logic b, logic d, logic p, logic [2:0] v, logic [7:0] t);
    logic [2:0] ev;
    ev = m[k].act ? 3'(m[k].p / dw[k]) : 3'd0;
    chk($sformatf("busy_d%0d", dw[k]), 32'(b), 32'(m[k].act));
    chk($sformatf("done_d%0d", dw[k]), 32'(d), 32'(m[k].fin));
    chk($sformatf("vec_d%0d",  dw[k]), 32'(v), 32'(ev));
    chk($sformatf("tbl_d%0d",  dw[k]), 32'(t), 32'(m[k].tbl));
    chk($sformatf("pass_d%0d", dw[k]), 32'(p), 32'(m[k].valid && m[k].tbl == 8'hC8));
  endtask

  task automatic check_all();
    chk_inst(0, if4.busy, if4.done, if4.pass, if4.vec, if4.tbl);
    chk_inst(1, if1.busy, if1.done, if1.pass, if1.vec, if1.tbl);
  endtask

  task automatic step();
    @(posedge clk);
    m_edge(0);
    m_edge(1);
    #1;
    check_all();
  endtask

  // asynchronous reset mid-cycle, held across one edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(if4.busy), 0);
    chk("rst_async_vec",  32'(if4.vec),  0);
    chk("rst_async_tbl",  32'(if4.tbl),  0);
    m_reset();
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  int lat4, lat1;

  initial begin
    m_reset();
    #1;
    check_all();
    #20 rst_n = 1'b1;
    step();

    // full sweep of the reference circuit, latency measured from the start edge
    func = 8'hC8; start = 1'b1;
    step();
    start = 1'b0;
    lat4 = -1; lat1 = -1;
    for (int n = 1; n <= 60; n++) begin
      if (if4.done && lat4 < 0) lat4 = n;
      if (if1.done && lat1 < 0) lat1 = n;
      step();
    end
    chk("lat_d4", 32'(lat4), 33);
    chk("lat_d1", 32'(lat1), 9);
    chk("tbl_c8_d4", 32'(if4.tbl), 32'h00C8);
    chk("pass_c8_d4", 32'(if4.pass), 1);

    // stuck-at-0 network
    func = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    chk("tbl_sa0", 32'(if4.tbl), 0);
    chk("pass_sa0", 32'(if4.pass), 0);

    // abort while VEC=3 with one dwell cycle already spent
    func = 8'hC8; start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
    chk("pre_abort_vec", 32'(if4.vec), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(if4.busy), 0);
    chk("abort_tbl", 32'(if4.tbl), 0);
    repeat (40) step();

    // start held high: restart right after FIN
    start = 1'b1;
    repeat (80) step();
    start = 1'b0;
    repeat (40) step();

    // reset in the middle of a sweep, then a clean sweep
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    async_reset();
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    chk("tbl_after_rst", 32'(if4.tbl), 32'h00C8);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(39) == 0);
      if (!m[0].act && !m[1].act && $urandom_range(15) == 0)
        func = ($urandom_range(1) == 0) ? 8'hC8 : 8'($urandom);
      if ($urandom_range(499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking exhaustive-stimulus stage that wraps a small combinational gate network under test, such as the AND-OR majority-style circuit Z = A·B + B·C.
- Upstream role: drives every input vector 0 … 2**N_IN−1 in ascending order, holding each for DWELL clocks.
- Downstream role: samples the DUT output Z once per vector into a truth-table register, then compares the table against an expected signature.
- Replaces hand-written per-vector delay sequences with a start/done handshake usable on hardware.

Parameters:
- N_IN, 3, number of DUT inputs; VEC width; table has 2**N_IN entries.
- DWELL, 4, clocks each vector is held; must be ≥1; Z sampled on the last held cycle.
- EXPECTED, 8'b1100_1000, golden truth table indexed by vector value (bit i = Z for VEC=i); default is A·B+B·C with VEC={A,B,C}.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request a sweep; sampled only in IDLE.
- ABORT  in  1  cancel a running sweep.
- Z_IN  in  1  DUT output, combinational function of VEC.
- VEC  out  N_IN  DUT input vector; MSB drives A, LSB drives C.
- BUSY  out  1  high while sweeping.
- DONE  out  1  one-cycle pulse when a sweep completes.
- TABLE  out  2**N_IN  captured truth table.
- PASS  out  1  TABLE==EXPECTED for a completed sweep.

Behaviour:
- Reset (async, RST_N=0): state IDLE; VEC=0, BUSY=0, DONE=0, TABLE=0, PASS=0, idx=0, dwell=0, valid=0.
- States: IDLE, DRIVE, FIN. Encoding is binary, 2 bits.
- IDLE:
  - BUSY=0, VEC=0.
  - START=1 at an edge → TABLE←0, valid←0, idx←0, dwell←0, next state DRIVE.
  - ABORT is ignored in IDLE.
- DRIVE:
  - BUSY=1, VEC=idx. dwell increments every cycle.
  - When dwell==DWELL−1: TABLE[idx]←Z_IN at that edge.
  - At that same edge, if idx==2**N_IN−1 → FIN; else idx←idx+1, dwell←0.
  - ABORT=1 has priority over sampling. At that edge: → IDLE, VEC←0, TABLE keeps already-captured bits, valid stays 0, no DONE pulse.
- FIN (exactly one cycle):
  - DONE=1, BUSY=0, VEC=0, valid←1, then → IDLE.
  - START during FIN is ignored.
- PASS = valid && (TABLE==EXPECTED). It is first high in the FIN cycle and holds until the next accepted START, an ABORT-free restart, or reset.
- START while BUSY is ignored; no queuing.
- Latency: START sampled at edge 0 → DRIVE occupies 2**N_IN·DWELL cycles → DONE high in cycle 2**N_IN·DWELL+1 (cycle 33 for defaults).
- Width rules:
  - idx is N_IN bits; the terminal-index test prevents wrap.
  - dwell counter width is clog2(DWELL+1) and never exceeds DWELL−1.
- Z_IN is sampled at the clock edge. The DUT is combinational, so DWELL=1 is legal; DWELL>1 gives settle margin for gate-delay simulation.
- Reset mid-sweep returns immediately to the reset values above; no DONE pulse.

Decomposition:
- Shared package tts_pkg holds:
  - state encoding constants (ST_IDLE=0, ST_DRIVE=1, ST_FIN=2);
  - golden constant EXP_C3_1=8'b1100_1000 for the existing 3-input AND-OR circuit.
- One sub-module, dwell_counter:
  - parameter DWELL;
  - inputs CLK, RST_N, clr, en;
  - output last (dwell==DWELL−1).
- FSM, idx register and TABLE stay in the top module.

Test Plan:
1. DUT = A·B+B·C, defaults, START pulse at cycle 0 → VEC steps 0..7, each held 4 cycles; DONE pulses at cycle 33; TABLE=8'hC8; PASS=1.
2. DUT with stuck-at-0 output (Z_IN=0) → DONE at cycle 33; TABLE=8'h00; PASS=0.
3. ABORT asserted while VEC=3, dwell=1 → next cycle BUSY=0, VEC=0; no DONE; TABLE=8'h00 (bits 0–2 were 0; bit 3 not captured); PASS=0.
4. START re-pulsed every cycle during a sweep → single DONE at cycle 33; sweep timing unchanged; back-to-back START in the cycle after FIN starts a new sweep with TABLE cleared and PASS=0.
5. RST_N low for 1 cycle at cycle 15 (asynchronous, mid-clock) → all outputs 0 immediately; START at cycle 20 → DONE at cycle 53 with TABLE=8'hC8.
6. DWELL=1, N_IN=3 → VEC changes every cycle; DONE at cycle 9; TABLE=8'hC8; PASS=1.
